// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   Issue/retire controller for a 32x32 combinational signed multiplier.
//   A request (in_a, in_b, in_hi, in_tag) is accepted over a valid/ready
//   handshake. The operands are held on mul_a/mul_b for MUL_CYCLES clock
//   edges. The product word is then captured and offered downstream over a
//   second valid/ready handshake. Only one request is in flight at a time.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   in_valid/ready   request handshake
//   in_a, in_b       signed operands
//   in_hi            0: product[31:0], 1: product[63:32]
//   in_tag           opaque tag returned with the result
//   mul_a, mul_b     registered operands driving the multiplier
//   mul_product      combinational 64-bit product from the multiplier
//   out_valid/ready  result handshake
//   out_result       selected product word
//   out_ovf          product does not fit in 32 signed bits
//   out_tag          tag of the request
//   busy             high while a request is waiting or being retired

module mul_issue_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_hi,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_cfg
        $error("mul_issue_ctrl: MUL_CYCLES must be within 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic             hi_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hi_q       <= 1'b0;
            tag_q      <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_tag    <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mul_a    <= in_a;
                        mul_b    <= in_b;
                        hi_q     <= in_hi;
                        tag_q    <= in_tag;
                        cnt      <= CNT_LOAD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        out_result <= hi_q ? mul_product[63:32] : mul_product[31:0];
                        // Overflow: upper word is not the sign extension of bit 31.
                        out_ovf    <= (mul_product[63:32] != {32{mul_product[31]}});
                        out_tag    <= tag_q;
                        out_valid  <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    cnt       <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

    localparam int NI = 3;
    localparam int MC [NI] = '{2, 1, 15};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid [NI];
    logic        in_ready [NI];
    logic [31:0] in_a [NI];
    logic [31:0] in_b [NI];
    logic        in_hi [NI];
    logic [3:0]  in_tag [NI];
    logic [31:0] mul_a [NI];
    logic [31:0] mul_b [NI];
    logic [63:0] mul_product [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic [31:0] out_result [NI];
    logic        out_ovf [NI];
    logic [3:0]  out_tag [NI];
    logic        busy [NI];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational multiplier.
    for (genvar g = 0; g < NI; g++) begin : g_mul
        assign mul_product[g] = longint'($signed(mul_a[g])) * longint'($signed(mul_b[g]));
    end

    mul_issue_ctrl #(.MUL_CYCLES(2), .TAG_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_hi(in_hi[0]), .in_tag(in_tag[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_product(mul_product[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(out_result[0]),
        .out_ovf(out_ovf[0]), .out_tag(out_tag[0]), .busy(busy[0]));

    mul_issue_ctrl #(.MUL_CYCLES(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_hi(in_hi[1]), .in_tag(in_tag[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_product(mul_product[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(out_result[1]),
        .out_ovf(out_ovf[1]), .out_tag(out_tag[1]), .busy(busy[1]));

    mul_issue_ctrl #(.MUL_CYCLES(15), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .in_hi(in_hi[2]), .in_tag(in_tag[2]),
        .mul_a(mul_a[2]), .mul_b(mul_b[2]), .mul_product(mul_product[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_result(out_result[2]),
        .out_ovf(out_ovf[2]), .out_tag(out_tag[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full signed product, then word select and 32-bit fit test.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic hi);
        longint      p;
        logic [63:0] u;
        logic        ovf;
        p   = longint'($signed(a)) * longint'($signed(b));
        u   = p;
        ovf = (p != longint'($signed(u[31:0])));
        return {ovf, hi ? u[63:32] : u[31:0]};
    endfunction

    // Called and returns at "#1 after a rising edge". If out_ready[k] is low the
    // task returns with the result still pending.
    task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic hi, input logic [3:0] tag,
                          input logic [31:0] er, input logic eo);
        int n;
        n = 0;
        while (!in_ready[k] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_req", 64'(in_ready[k]), 64'd1);
        in_a[k] = a; in_b[k] = b; in_hi[k] = hi; in_tag[k] = tag; in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        chk("busy_in_wait", 64'(busy[k]), 64'd1);
        chk("in_ready_in_wait", 64'(in_ready[k]), 64'd0);
        n = 0;
        while (!out_valid[k] && n < 40) begin
            chk("mul_a_held", 64'(mul_a[k]), 64'(a));
            chk("mul_b_held", 64'(mul_b[k]), 64'(b));
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(MC[k]));
        chk("out_result", 64'(out_result[k]), 64'(er));
        chk("out_ovf", 64'(out_ovf[k]), 64'(eo));
        chk("out_tag", 64'(out_tag[k]), 64'(tag));
        chk("in_ready_in_done", 64'(in_ready[k]), 64'd0);
        if (out_ready[k]) begin
            @(posedge clk); #1;
            chk("valid_after_hs", 64'(out_valid[k]), 64'd0);
            chk("ready_after_hs", 64'(in_ready[k]), 64'd1);
            chk("busy_after_hs", 64'(busy[k]), 64'd0);
        end
    endtask

    task automatic ref_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic hi, input logic [3:0] tag);
        logic [32:0] r;
        r = ref_mul(a, b, hi);
        do_req(k, a, b, hi, tag, r[31:0], r[32]);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0: return 32'($signed($urandom_range(0, 200)) - 100);
            1: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int vcount;
        logic [31:0] hold_res;
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0; in_hi[i] = 1'b0;
            in_tag[i] = '0; out_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
        chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_mul_a", 64'(mul_a[0]), 64'd0);
        chk("rst_out_result", 64'(out_result[0]), 64'd0);
        chk("rst_out_tag", 64'(out_tag[0]), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner operands on the default build.
        do_req(0, 32'd7, 32'hFFFF_FFFD, 1'b0, 4'd5, 32'hFFFF_FFEB, 1'b0);
        do_req(0, 32'd7, 32'hFFFF_FFFD, 1'b1, 4'd6, 32'hFFFF_FFFF, 1'b0);
        do_req(0, 32'h0001_0000, 32'h0001_0000, 1'b0, 4'd1, 32'h0000_0000, 1'b1);
        do_req(0, 32'h0001_0000, 32'h0001_0000, 1'b1, 4'd2, 32'h0000_0001, 1'b1);
        do_req(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 4'd3, 32'h4000_0000, 1'b1);
        do_req(0, 32'h8000_0000, 32'd1, 1'b0, 4'd4, 32'h8000_0000, 1'b0);

        // Backpressure: result must stay put and a new request must be ignored.
        out_ready[0] = 1'b0;
        do_req(0, 32'd12345, 32'hFFFF_FF00, 1'b0, 4'd9, 32'hFFCF_C700, 1'b0);
        hold_res = out_result[0];
        for (int c = 0; c < 5; c++) begin
            in_valid[0] = (c == 2);
            in_a[0] = 32'hDEAD_BEEF; in_b[0] = 32'h1234_5678; in_tag[0] = 4'd15;
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid[0]), 64'd1);
            chk("bp_result", 64'(out_result[0]), 64'(hold_res));
            chk("bp_tag", 64'(out_tag[0]), 64'd9);
            chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
            chk("bp_mul_a", 64'(mul_a[0]), 64'd12345);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 64'(out_valid[0]), 64'd0);
        chk("bp_release_ready", 64'(in_ready[0]), 64'd1);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid[0]) vcount++;
        end
        chk("bp_ignored_req", 64'(vcount), 64'd0);

        // Reset during WAIT aborts the request.
        in_a[0] = 32'd100; in_b[0] = 32'd200; in_tag[0] = 4'd7; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("abort_busy", 64'(busy[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid[0]), 64'd0);
        chk("abort_in_ready", 64'(in_ready[0]), 64'd1);
        chk("abort_mul_a", 64'(mul_a[0]), 64'd0);
        chk("abort_mul_b", 64'(mul_b[0]), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid[0]) vcount++;
        end
        chk("abort_no_result", 64'(vcount), 64'd0);

        // Randomized back-to-back traffic on every build.
        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 20; r++) begin
                ref_req(k, rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
